// File: rtl/oci_dct_pkg.sv
// Shared constants and helpers for the OCI data-compress-trace packer.
// Frames are 2 bits wide; fifteen of them fill one 30-bit word.
package oci_dct_pkg;

    localparam int FRAME_W = 2;
    localparam int FRAMES  = 15;
    localparam int BUF_W   = FRAME_W * FRAMES;
    localparam int CNT_W   = 4;
    localparam int DROP_W  = 8;

    localparam logic [CNT_W-1:0]  FULL_CNT = 4'd15;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    typedef logic [FRAME_W-1:0] frame_t;

    // The oldest frame ends up in the most significant slot.
    function automatic logic [BUF_W-1:0] shift_in(input logic [BUF_W-1:0] acc, input frame_t f);
        return {acc[BUF_W-FRAME_W-1:0], f};
    endfunction

endpackage

// File: rtl/timestamp_timer_nios2_processor_oci_dct_packer.sv
// Packs 2-bit DCT trace frames into 30-bit words behind a one-stage valid/ready output slot,
// exports the live accumulator and generates the end-of-test flags.
module timestamp_timer_nios2_processor_oci_dct_packer
    import oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    output logic               frame_ready,
    input  logic               flush,
    input  logic               end_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BUF_W-1:0]   out_buffer,
    output logic [CNT_W-1:0]   out_count,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_ending,
    output logic               test_has_ended,
    output logic [DROP_W-1:0]  drop_cnt
);

    logic [BUF_W-1:0] acc_buf;
    logic [CNT_W-1:0] acc_cnt;
    logic             flush_pend;

    logic [BUF_W-1:0] acc_buf_nxt;
    logic [CNT_W-1:0] acc_cnt_nxt;
    logic             flush_pend_nxt;
    logic             accept;
    logic             launch;

    assign frame_ready = (acc_cnt < FULL_CNT) & ~test_has_ended;
    assign accept      = frame_valid & frame_ready;
    assign launch      = ((acc_cnt == FULL_CNT) | (flush_pend & (acc_cnt != 4'd0)))
                       & (~out_valid | out_ready);
    assign dct_buffer  = acc_buf;
    assign dct_count   = acc_cnt;

    // Accumulator and flush-pending next state; a frame arriving on a launch starts the next word.
    always_comb begin
        acc_buf_nxt    = acc_buf;
        acc_cnt_nxt    = acc_cnt;
        flush_pend_nxt = flush_pend;
        if (launch) begin
            if (accept) begin
                acc_buf_nxt = {{(BUF_W-FRAME_W){1'b0}}, frame_data};
                acc_cnt_nxt = 4'd1;
            end else begin
                acc_buf_nxt = '0;
                acc_cnt_nxt = 4'd0;
            end
        end else if (accept) begin
            acc_buf_nxt = shift_in(acc_buf, frame_data);
            acc_cnt_nxt = acc_cnt + 4'd1;
        end else begin
            acc_buf_nxt = acc_buf;
            acc_cnt_nxt = acc_cnt;
        end
        if (flush | end_req) begin
            flush_pend_nxt = 1'b1;
        end else if (launch | ((acc_cnt == 4'd0) & ~accept)) begin
            flush_pend_nxt = 1'b0;
        end else begin
            flush_pend_nxt = flush_pend;
        end
    end

    // Accumulator, output slot, drop counter and end-of-test flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_buf        <= '0;
            acc_cnt        <= 4'd0;
            flush_pend     <= 1'b0;
            out_valid      <= 1'b0;
            out_buffer     <= '0;
            out_count      <= 4'd0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
            drop_cnt       <= 8'd0;
        end else begin
            acc_buf    <= acc_buf_nxt;
            acc_cnt    <= acc_cnt_nxt;
            flush_pend <= flush_pend_nxt;
            if (launch) begin
                out_valid  <= 1'b1;
                out_buffer <= acc_buf;
                out_count  <= acc_cnt;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end else begin
                out_valid  <= out_valid;
            end
            if (frame_valid & ~frame_ready & (drop_cnt != DROP_MAX)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
            if (end_req) begin
                test_ending <= 1'b1;
            end else begin
                test_ending <= test_ending;
            end
            // Drain is complete once nothing is buffered and the output slot is empty.
            if (test_ending & (acc_cnt == 4'd0) & ~out_valid) begin
                test_has_ended <= 1'b1;
            end else begin
                test_has_ended <= test_has_ended;
            end
        end
    end

endmodule

// File: tb/tb_timestamp_timer_nios2_processor_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: directed frame sequences push expected words,
// a monitor pops and compares on every output handshake.
module tb_timestamp_timer_nios2_processor_oci_dct_packer;
    import oci_dct_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_ready;
    logic               flush;
    logic               end_req;
    logic               out_valid;
    logic               out_ready;
    logic [BUF_W-1:0]   out_buffer;
    logic [CNT_W-1:0]   out_count;
    logic [BUF_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               test_ending;
    logic               test_has_ended;
    logic [DROP_W-1:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [CNT_W+BUF_W-1:0] exp_q[$];
    logic [CNT_W+BUF_W-1:0] mon_exp;

    timestamp_timer_nios2_processor_oci_dct_packer dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .frame_ready(frame_ready), .flush(flush), .end_req(end_req), .out_valid(out_valid),
        .out_ready(out_ready), .out_buffer(out_buffer), .out_count(out_count),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every completed output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got buffer %h count %0d, expected no word", out_buffer, out_count);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_count, out_buffer} !== mon_exp) begin
                    errors++;
                    $display("FAIL word: got buffer %h count %0d, expected buffer %h count %0d",
                             out_buffer, out_count, mon_exp[BUF_W-1:0], mon_exp[CNT_W+BUF_W-1:BUF_W]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [BUF_W-1:0] b, input logic [CNT_W-1:0] c);
        exp_q.push_back({c, b});
    endtask

    // Offer one frame only once frame_ready is high, so no drop is ever caused here.
    task automatic send_frame(input logic [FRAME_W-1:0] d);
        int n = 0;
        frame_valid = 1'b0;
        while (!frame_ready && n < 200) begin
            step();
            n++;
        end
        if (!frame_ready) begin
            checks++;
            errors++;
            $display("FAIL frame_ready_timeout: got 0 expected 1");
        end
        frame_valid = 1'b1;
        frame_data  = d;
        step();
        frame_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_out_buffer"}, {2'd0, out_buffer}, 32'd0);
        check({name, "_counts"}, {24'd0, out_count, dct_count}, 32'd0);
        check({name, "_dct_buffer"}, {2'd0, dct_buffer}, 32'd0);
        check({name, "_flags"}, {29'd0, test_ending, test_has_ended, frame_ready}, 32'd1);
        check({name, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; frame_valid = 1'b0; frame_data = 2'd0;
        flush = 1'b0; end_req = 1'b0; out_ready = 1'b0;
        step(); step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // Full word of cycling frames 1,2,3,0,... with the output free.
        out_ready = 1'b1;
        push_word(30'h1B1B1B1B, 4'd15);
        for (int i = 0; i < 15; i++) send_frame(2'((i + 1) % 4));
        wait_drain();
        check("t1_dct_count", {28'd0, dct_count}, 32'd0);

        // Three frames then flush.
        for (int i = 0; i < 3; i++) send_frame(2'b11);
        check("t2_dct_count_pre", {28'd0, dct_count}, 32'd3);
        check("t2_dct_buffer_pre", {2'd0, dct_buffer}, 32'h3F);
        push_word(30'h3F, 4'd3);
        flush = 1'b1; step(); flush = 1'b0;
        wait_drain();
        step(); step();
        check("t2_dct_count_post", {28'd0, dct_count}, 32'd0);

        // Flush with an empty accumulator emits nothing.
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t2_empty_flush_no_word", {31'd0, out_valid}, 32'd0);
        check("t2_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // Output blocked: one word held, a second fills the accumulator, then drops.
        out_ready = 1'b0;
        push_word(30'h06C6C6C6, 4'd15);
        push_word(30'h39393939, 4'd15);
        for (int i = 0; i < 15; i++) send_frame(2'(i % 4));
        for (int i = 0; i < 15; i++) send_frame(2'(3 - (i % 4)));
        check("t3_frame_ready_full", {31'd0, frame_ready}, 32'd0);
        check("t3_held_word", {27'd0, out_valid, out_count}, {27'd0, 1'b1, 4'd15});
        frame_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        frame_valid = 1'b0;
        check("t3_drop_cnt", {24'd0, drop_cnt}, 32'd5);
        out_ready = 1'b1;
        wait_drain();

        // 15th frame accepted in the same cycle the blocked word is released.
        out_ready = 1'b0;
        push_word(30'h15555555, 4'd15);
        for (int i = 0; i < 15; i++) send_frame(2'b01);
        for (int i = 0; i < 14; i++) send_frame(2'b10);
        push_word(30'h2AAAAAAB, 4'd15);
        out_ready = 1'b1;
        send_frame(2'b11);
        check("t4_slot_freed", {27'd0, out_valid, dct_count}, {27'd0, 1'b0, 4'd15});
        step();
        check("t4_latency_valid", {27'd0, out_valid, out_count}, {27'd0, 1'b1, 4'd15});
        wait_drain();
        check("t4_no_drop", {24'd0, drop_cnt}, 32'd5);

        // End of test with four frames buffered.
        push_word(30'h6C, 4'd4);
        send_frame(2'd1); send_frame(2'd2); send_frame(2'd3); send_frame(2'd0);
        end_req = 1'b1; step(); end_req = 1'b0;
        check("t5_test_ending", {31'd0, test_ending}, 32'd1);
        n = 0;
        while (!test_has_ended && n < 50) begin
            step();
            n++;
        end
        check("t5_test_has_ended", {31'd0, test_has_ended}, 32'd1);
        wait_drain();
        check("t5_refuse", {30'd0, frame_ready, test_ending}, 32'd1);
        frame_valid = 1'b1; step(); frame_valid = 1'b0;
        check("t5_drop_after_end", {24'd0, drop_cnt}, 32'd6);

        // Reset while a word is held and seven frames are buffered.
        reset = 1'b1; step(); reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_frame(2'b00);
        for (int i = 0; i < 7; i++) send_frame(2'b10);
        check("t6_pre_dct_count", {28'd0, dct_count}, 32'd7);
        check("t6_pre_dct_buffer", {2'd0, dct_buffer}, 32'h2AAA);
        check("t6_pre_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1; step();
        check_reset_state("t6_reset");
        reset = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t6_no_glitch", {31'd0, out_valid}, 32'd0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
